// File: rtl/sensor_mm_pkg.sv
// Shared definitions for the sensor sample memory-mapped writer and the
// on-chip memory it fills: default buffer geometry and the writer FSM states.
package sensor_mm_pkg;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DEPTH  = 32000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/mm_wrap_counter.sv
// Word pointer that walks 0..DEPTH-1 and wraps back to 0.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   clear           load zero (takes priority over inc)
//   inc             advance by one, wrapping after DEPTH-1
//   count           current pointer value
//   count_inc       value the pointer takes on the next inc
//   at_last         pointer sits at DEPTH-1 (next inc wraps)
module mm_wrap_counter #(
  parameter int W     = 15,
  parameter int DEPTH = 32000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] count_inc,
  output logic         at_last
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  assign at_last   = (count == LAST);
  assign count_inc = at_last ? '0 : count + W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (inc)   count <= count_inc;
  end

endmodule

// File: rtl/sensor_sample_mm_writer.sv
// Captures a 32-bit valid/ready sample stream and writes one word per sample
// to a word-addressed Avalon-MM memory, either as a single-shot linear
// capture or as a continuous ring buffer.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, stop, continuous    capture control (continuous sampled at start)
//   snk_valid/data/ready       sample stream input
//   avm_*                      Avalon-MM write initiator
//   busy, done, wrapped        capture status
//   wr_ptr, fill_level         next word offset, number of valid words
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no capture; waits for start
// ST_CAPTURE | accepting samples and issuing writes
// ST_DRAIN   | stop seen with a stalled write; waits for it to complete
module sensor_sample_mm_writer
  import sensor_mm_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic              snk_valid,
  input  logic [31:0]       snk_data,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              wrapped,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   fill_level
);

  localparam int                FILL_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   FILL_MAX  = FILL_W'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic              mode_cont;
  logic              wr_done;
  logic              accept;
  logic              single_end;
  logic              ptr_clear;
  logic [ADDR_W-1:0] ptr_inc;
  logic              ptr_last;

  assign avm_byteenable = 4'hF;
  assign wr_done        = avm_write & ~avm_waitrequest;
  assign accept         = snk_valid & snk_ready;
  assign single_end     = wr_done & ptr_last & ~mode_cont;
  assign ptr_clear      = (state == ST_IDLE) & start;

  mm_wrap_counter #(
    .W     (ADDR_W),
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk       (clk),
    .reset     (reset),
    .clear     (ptr_clear),
    .inc       (wr_done),
    .count     (wr_ptr),
    .count_inc (ptr_inc),
    .at_last   (ptr_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // snk_ready is also held low while stop is asserted and on the final write
  // of a single shot, so no sample is accepted that could never be written.
  always_comb begin
    state_nxt = state;
    snk_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        snk_ready = ~stop & ~single_end & (~avm_write | ~avm_waitrequest);
        if (single_end)
          state_nxt = ST_IDLE;
        else if (stop)
          state_nxt = (avm_write & avm_waitrequest) ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (wr_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_cont     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      wrapped       <= 1'b0;
      fill_level    <= '0;
      avm_write     <= 1'b0;
      avm_address   <= BASE_ADDR;
      avm_writedata <= '0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      done <= (state != ST_IDLE) & (state_nxt == ST_IDLE);

      if (ptr_clear) begin
        mode_cont  <= continuous;
        wrapped    <= 1'b0;
        fill_level <= '0;
      end else if (wr_done) begin
        if (fill_level != FILL_MAX) fill_level <= fill_level + FILL_W'(1);
        if (ptr_last & mode_cont)   wrapped    <= 1'b1;
      end

      // A sample accepted in a completion cycle targets the post-increment
      // pointer, which the counter has not registered yet.
      if (accept) begin
        avm_write     <= 1'b1;
        avm_writedata <= snk_data;
        avm_address   <= BASE_ADDR + (wr_done ? ptr_inc : wr_ptr);
      end else if (wr_done) begin
        avm_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sensor_sample_mm_writer.sv
module tb_sensor_sample_mm_writer;

  localparam int AW   = 6;
  localparam int DEP  = 8;
  localparam int BASE = 20;
  localparam logic [AW:0] FULL = 7'd8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          continuous = 1'b0;
  logic          snk_valid = 1'b0;
  logic [31:0]   snk_data = '0;
  logic          snk_ready;
  logic [AW-1:0] avm_address;
  logic [3:0]    avm_byteenable;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic          avm_waitrequest = 1'b0;
  logic          busy;
  logic          done;
  logic          wrapped;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   fill_level;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0]   src_q[$];
  logic [31:0]   exp_q[$];
  logic [31:0]   wd_q[$];
  logic [AW-1:0] wa_q[$];
  int            wc_q[$];
  int            dn_q[$];
  logic          dn_busy_q[$];

  sensor_sample_mm_writer #(
    .ADDR_W (AW),
    .DEPTH  (DEP),
    .BASE   (BASE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .stop            (stop),
    .continuous      (continuous),
    .snk_valid       (snk_valid),
    .snk_data        (snk_data),
    .snk_ready       (snk_ready),
    .avm_address     (avm_address),
    .avm_byteenable  (avm_byteenable),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .wrapped         (wrapped),
    .wr_ptr          (wr_ptr),
    .fill_level      (fill_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: logs every completed write and every done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (avm_write && !avm_waitrequest) begin
        wa_q.push_back(avm_address);
        wd_q.push_back(avm_writedata);
        wc_q.push_back(cyc);
      end
      if (done) begin
        dn_q.push_back(cyc);
        dn_busy_q.push_back(busy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    src_q.delete(); exp_q.delete(); wd_q.delete(); wa_q.delete();
    wc_q.delete(); dn_q.delete(); dn_busy_q.delete();
  endtask

  task automatic pulse_start(input logic cont);
    start = 1'b1;
    continuous = cont;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 0;
  endtask

  // Presents src_q entries in order; each accepted one joins the expected list.
  task automatic send_samples(input int n, input int stall_pct);
    int  sent = 0;
    int  guard = 0;
    logic acc;
    while (sent < n && guard < n * 20 + 50) begin
      snk_valid = 1'b1;
      snk_data = src_q[0];
      avm_waitrequest = ($urandom_range(0, 99) < stall_pct);
      @(negedge clk);
      acc = snk_ready;
      step();
      if (acc) begin
        exp_q.push_back(src_q.pop_front());
        sent++;
      end
      guard++;
    end
    snk_valid = 1'b0;
    n_tests++;
    if (sent !== n) begin
      n_fail++;
      $display("FAIL send_timeout: accepted %0d samples, required %0d", sent, n);
    end
  endtask

  task automatic flush_writes();
    int guard = 0;
    snk_valid = 1'b0;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    while (avm_write && guard < 50) begin
      step();
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (avm_write !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_timeout: avm_write=%b required 0", avm_write);
    end
    step();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (snk_ready !== 1'b0) begin n_fail++; $display("FAIL reset_snk_ready: got %b want 0", snk_ready); end
    n_tests++; if (avm_write !== 1'b0) begin n_fail++; $display("FAIL reset_avm_write: got %b want 0", avm_write); end
    n_tests++; if (avm_address !== AW'(BASE)) begin n_fail++; $display("FAIL reset_address: got %0d want %0d", avm_address, BASE); end
    n_tests++; if (avm_writedata !== 32'h0) begin n_fail++; $display("FAIL reset_writedata: got %h want 0", avm_writedata); end
    n_tests++; if (avm_byteenable !== 4'hF) begin n_fail++; $display("FAIL reset_byteenable: got %h want f", avm_byteenable); end
    n_tests++; if ({busy, done, wrapped} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b want 000", {busy, done, wrapped}); end
    n_tests++; if (wr_ptr !== '0 || fill_level !== '0) begin n_fail++; $display("FAIL reset_counters: wr_ptr=%0d fill=%0d want 0/0", wr_ptr, fill_level); end
    @(posedge clk);
    #1 reset = 1'b0;
    step();
  endtask

  task automatic test_idle_controls();
    clear_logs();
    pulse_stop();
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_stop: busy=%b done=%b want 0/0", busy, done); end
    step();
    start = 1'b1; stop = 1'b1; continuous = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL start_stop_same: busy=%b done=%b want 1/0", busy, done); end
    step();
    pulse_stop();
    @(negedge clk);
    n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_no_pending: done=%b busy=%b want 1/0", done, busy); end
    step();
  endtask

  task automatic test_single_shot();
    clear_logs();
    for (int i = 0; i < 8; i++) src_q.push_back(32'hA0 + i);
    pulse_start(1'b0);
    @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ss_busy_rise: got %b want 1", busy); end
    step();
    send_samples(8, 0);
    flush_writes();
    n_tests++; if (wa_q.size() !== 8) begin n_fail++; $display("FAIL ss_write_count: got %0d want 8", wa_q.size()); end
    for (int k = 0; k < wa_q.size() && k < exp_q.size(); k++) begin
      n_tests++;
      if (wa_q[k] !== AW'(BASE + k % DEP) || wd_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL ss_write[%0d]: got addr %0d data %h want addr %0d data %h", k, wa_q[k], wd_q[k], BASE + k % DEP, exp_q[k]);
      end
    end
    if (wc_q.size() == 8) begin
      n_tests++; if (wc_q[7] - wc_q[0] !== 7) begin n_fail++; $display("FAIL ss_consecutive: span %0d want 7", wc_q[7] - wc_q[0]); end
    end
    n_tests++;
    if (dn_q.size() !== 1 || wc_q.size() == 0) begin
      n_fail++; $display("FAIL ss_done_count: got %0d want 1", dn_q.size());
    end else if (dn_q[0] !== wc_q[wc_q.size()-1] + 1 || dn_busy_q[0] !== 1'b0) begin
      n_fail++; $display("FAIL ss_done_timing: done cycle %0d busy %b want %0d busy 0", dn_q[0], dn_busy_q[0], wc_q[wc_q.size()-1] + 1);
    end
    n_tests++; if (fill_level !== FULL || wrapped !== 1'b0 || wr_ptr !== '0) begin n_fail++; $display("FAIL ss_final: fill=%0d wrapped=%b ptr=%0d want 8/0/0", fill_level, wrapped, wr_ptr); end
  endtask

  task automatic test_continuous(input int n, input int stall_pct);
    int exp_fill;
    clear_logs();
    for (int i = 0; i < n; i++) src_q.push_back($urandom);
    pulse_start(1'b1);
    send_samples(n, stall_pct);
    flush_writes();
    n_tests++; if (wa_q.size() !== n) begin n_fail++; $display("FAIL cont_write_count: got %0d want %0d", wa_q.size(), n); end
    for (int k = 0; k < wa_q.size() && k < exp_q.size(); k++) begin
      n_tests++;
      if (wa_q[k] !== AW'(BASE + k % DEP) || wd_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL cont_write[%0d]: got addr %0d data %h want addr %0d data %h", k, wa_q[k], wd_q[k], BASE + k % DEP, exp_q[k]);
      end
    end
    exp_fill = (n < DEP) ? n : DEP;
    n_tests++; if (wr_ptr !== AW'(n % DEP)) begin n_fail++; $display("FAIL cont_wr_ptr: got %0d want %0d", wr_ptr, n % DEP); end
    n_tests++; if (fill_level !== (AW+1)'(exp_fill)) begin n_fail++; $display("FAIL cont_fill: got %0d want %0d", fill_level, exp_fill); end
    n_tests++; if (wrapped !== (n >= DEP)) begin n_fail++; $display("FAIL cont_wrapped: got %b want %b", wrapped, n >= DEP); end
    n_tests++; if (busy !== 1'b1 || dn_q.size() !== 0) begin n_fail++; $display("FAIL cont_still_busy: busy=%b dones=%0d want 1/0", busy, dn_q.size()); end
    pulse_stop();
    @(negedge clk);
    n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL cont_stop_done: done=%b busy=%b want 1/0", done, busy); end
    step();
  endtask

  task automatic test_stall_and_stop();
    logic [31:0] d[5];
    clear_logs();
    for (int i = 0; i < 5; i++) d[i] = $urandom;
    pulse_start(1'b0);
    snk_valid = 1'b1; snk_data = d[0]; avm_waitrequest = 1'b0;
    @(negedge clk);
    n_tests++; if (snk_ready !== 1'b1) begin n_fail++; $display("FAIL stall_first_ready: got %b want 1", snk_ready); end
    step();
    snk_data = d[1];
    @(negedge clk);
    n_tests++; if (avm_write !== 1'b1 || snk_ready !== 1'b1) begin n_fail++; $display("FAIL stall_b2b: write=%b ready=%b want 1/1", avm_write, snk_ready); end
    step();
    snk_data = d[2]; avm_waitrequest = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) avm_waitrequest = 1'b0;
      @(negedge clk);
      n_tests++;
      if (avm_write !== 1'b1 || avm_address !== AW'(BASE + 1) || avm_writedata !== d[1] || snk_ready !== (c == 3)) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: write=%b addr=%0d data=%h ready=%b want 1/%0d/%h/%b", c, avm_write, avm_address, avm_writedata, snk_ready, BASE + 1, d[1], c == 3);
      end
      step();
    end
    snk_data = d[3];
    step();
    snk_valid = 1'b0; avm_waitrequest = 1'b1; stop = 1'b1;
    @(negedge clk);
    n_tests++; if (avm_write !== 1'b1 || avm_address !== AW'(BASE + 3)) begin n_fail++; $display("FAIL drain_pending: write=%b addr=%0d want 1/%0d", avm_write, avm_address, BASE + 3); end
    step();
    stop = 1'b0; snk_valid = 1'b1; snk_data = d[4];
    @(negedge clk);
    n_tests++; if (snk_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL drain_state: ready=%b busy=%b want 0/1", snk_ready, busy); end
    step();
    avm_waitrequest = 1'b0;
    @(negedge clk);
    n_tests++; if (snk_ready !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL drain_complete: ready=%b done=%b want 0/0", snk_ready, done); end
    step();
    snk_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (done !== 1'b1 || busy !== 1'b0 || avm_write !== 1'b0) begin n_fail++; $display("FAIL drain_done: done=%b busy=%b write=%b want 1/0/0", done, busy, avm_write); end
    n_tests++; if (fill_level !== 7'd4 || wr_ptr !== 6'd4) begin n_fail++; $display("FAIL drain_counts: fill=%0d ptr=%0d want 4/4", fill_level, wr_ptr); end
    for (int i = 0; i < 4; i++) exp_q.push_back(d[i]);
    n_tests++; if (wa_q.size() !== 4) begin n_fail++; $display("FAIL stall_write_count: got %0d want 4", wa_q.size()); end
    for (int k = 0; k < wa_q.size() && k < 4; k++) begin
      n_tests++;
      if (wa_q[k] !== AW'(BASE + k) || wd_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL stall_write[%0d]: got addr %0d data %h want addr %0d data %h", k, wa_q[k], wd_q[k], BASE + k, exp_q[k]);
      end
    end
    step();
  endtask

  task automatic test_start_ignored();
    clear_logs();
    for (int i = 0; i < 8; i++) src_q.push_back($urandom);
    pulse_start(1'b0);
    send_samples(5, 0);
    flush_writes();
    n_tests++; if (wr_ptr !== 6'd5) begin n_fail++; $display("FAIL ign_pre_ptr: got %0d want 5", wr_ptr); end
    pulse_start(1'b1);
    @(negedge clk);
    n_tests++; if (busy !== 1'b1 || wr_ptr !== 6'd5 || fill_level !== 7'd5) begin n_fail++; $display("FAIL ign_start: busy=%b ptr=%0d fill=%0d want 1/5/5", busy, wr_ptr, fill_level); end
    step();
    send_samples(1, 0);
    flush_writes();
    n_tests++; if (wr_ptr !== 6'd6) begin n_fail++; $display("FAIL ign_ptr_next: got %0d want 6", wr_ptr); end
    send_samples(2, 0);
    flush_writes();
    n_tests++; if (busy !== 1'b0 || dn_q.size() !== 1 || wrapped !== 1'b0) begin n_fail++; $display("FAIL ign_single_end: busy=%b dones=%0d wrapped=%b want 0/1/0", busy, dn_q.size(), wrapped); end
    for (int k = 0; k < wa_q.size() && k < exp_q.size(); k++) begin
      n_tests++;
      if (wa_q[k] !== AW'(BASE + k % DEP) || wd_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL ign_write[%0d]: got addr %0d data %h want addr %0d data %h", k, wa_q[k], wd_q[k], BASE + k % DEP, exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    clear_logs();
    pulse_start(1'b0);
    snk_valid = 1'b1; snk_data = $urandom; avm_waitrequest = 1'b0;
    step();
    snk_valid = 1'b0; avm_waitrequest = 1'b1;
    @(negedge clk);
    n_tests++; if (avm_write !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall: write=%b want 1", avm_write); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (avm_write !== 1'b0 || snk_ready !== 1'b0) begin n_fail++; $display("FAIL rst_async_write: write=%b ready=%b want 0/0", avm_write, snk_ready); end
    n_tests++; if (avm_address !== AW'(BASE) || avm_writedata !== 32'h0 || avm_byteenable !== 4'hF) begin n_fail++; $display("FAIL rst_async_bus: addr=%0d data=%h be=%h want %0d/0/f", avm_address, avm_writedata, avm_byteenable, BASE); end
    n_tests++; if ({busy, done, wrapped} !== 3'b000 || wr_ptr !== '0 || fill_level !== '0) begin n_fail++; $display("FAIL rst_async_status: bdw=%b ptr=%0d fill=%0d want 000/0/0", {busy, done, wrapped}, wr_ptr, fill_level); end
    @(posedge clk);
    #1 reset = 1'b0; avm_waitrequest = 1'b0;
    step();
    clear_logs();
    src_q.push_back($urandom);
    pulse_start(1'b0);
    send_samples(1, 0);
    flush_writes();
    n_tests++;
    if (wa_q.size() !== 1) begin
      n_fail++; $display("FAIL rst_restart_count: got %0d writes want 1", wa_q.size());
    end else if (wa_q[0] !== AW'(BASE) || wd_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL rst_restart_addr: got addr %0d data %h want %0d %h", wa_q[0], wd_q[0], BASE, exp_q[0]);
    end
    n_tests++; if (wr_ptr !== 6'd1 || fill_level !== 7'd1) begin n_fail++; $display("FAIL rst_restart_counts: ptr=%0d fill=%0d want 1/1", wr_ptr, fill_level); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_controls();
    test_single_shot();
    test_continuous(11, 0);
    test_stall_and_stop();
    test_start_ignored();
    test_continuous($urandom_range(5, 20), 40);
    test_continuous($urandom_range(3, 12), 25);
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
